// File: rtl/dpram_bist_pkg.sv
// dpram_bist_pkg: shared definitions for the dual-port RAM march BIST.
// Holds the FSM state type, the phase length and the march data pattern D(i).
package dpram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W0,
      R0,
      W1,
      R1,
      DRAIN,
      DONE
   } state_e;

   localparam int unsigned MAX_W = 64;

   // Every march phase visits each address exactly once.
   function automatic int unsigned phase_len(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

   // Callers truncate the result to their data width.
   function automatic logic [MAX_W-1:0] march_data(input logic [MAX_W-1:0] pattern,
                                                   input logic [MAX_W-1:0] idx);
      return pattern ^ idx;
   endfunction

endpackage

// File: rtl/dpram_bist_if.sv
// dpram_bist_if: test-side bus between the BIST controller (master) and the
// dual-port RAM (slave): write enables, addresses and data on both ports.
interface dpram_bist_if
   import dpram_bist_pkg::*;
#(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
) ();

   logic              wea;
   logic              web;
   logic [ADDR_W-1:0] addra;
   logic [ADDR_W-1:0] addrb;
   logic [DATA_W-1:0] dina;
   logic [DATA_W-1:0] dinb;
   logic [DATA_W-1:0] douta;
   logic [DATA_W-1:0] doutb;

   modport master (
      output wea, web, addra, addrb, dina, dinb,
      input  douta, doutb
   );

   modport slave (
      input  wea, web, addra, addrb, dina, dinb,
      output douta, doutb
   );

endinterface

// File: rtl/dpram_bist_checker.sv
// dpram_bist_checker: READ_LAT-deep compare pipeline, miscompare counter, pass flag.
// BIST_ERR_LOG_EN builds the first-fail log; otherwise fail_* are tied to 0.
module dpram_bist_checker
   import dpram_bist_pkg::*;
#(
   parameter int ADDR_W   = 2,
   parameter int DATA_W   = 4,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              fin,
   input  logic              rd_vld,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] exp_a,
   input  logic [DATA_W-1:0] exp_b,
   input  logic [DATA_W-1:0] douta,
   input  logic [DATA_W-1:0] doutb,
   output logic [ADDR_W+2:0] err_count,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic              fail_port,
   output logic [DATA_W-1:0] fail_data
);

   localparam int CNT_W = ADDR_W + 3;

   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] addr_a;
      logic [ADDR_W-1:0] addr_b;
      logic [DATA_W-1:0] exp_a;
      logic [DATA_W-1:0] exp_b;
   } stage_t;

   stage_t pipe_q [READ_LAT];
   stage_t pipe_d [READ_LAT];
   stage_t tail;

   logic             miss_a;
   logic             miss_b;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pass_q, pass_d;

   assign pipe_d[0] = '{vld: rd_vld, addr_a: addr_a, addr_b: addr_b, exp_a: exp_a, exp_b: exp_b};

   // The pipeline free-runs so that late compares overlap the following phase.
   for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_link
      assign pipe_d[gi] = pipe_q[gi-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < READ_LAT; k++) pipe_q[k] <= '0;
         cnt_q  <= '0;
         pass_q <= 1'b0;
      end else begin
         pipe_q <= pipe_d;
         cnt_q  <= cnt_d;
         pass_q <= pass_d;
      end
   end

   assign tail   = pipe_q[READ_LAT-1];
   assign miss_a = tail.vld && (douta != tail.exp_a);
   assign miss_b = tail.vld && (doutb != tail.exp_b);

   always_comb begin
      cnt_d  = cnt_q + CNT_W'(miss_a) + CNT_W'(miss_b);
      pass_d = pass_q;
      if (clr) begin
         cnt_d  = '0;
         pass_d = 1'b0;
      end else if (fin) begin
         pass_d = (cnt_d == '0);
      end
   end

   assign err_count = cnt_q;
   assign pass      = pass_q;

`ifdef BIST_ERR_LOG_EN
   logic              logged_q, logged_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic              fail_port_q, fail_port_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;

   always_comb begin
      logged_d    = logged_q;
      fail_addr_d = fail_addr_q;
      fail_port_d = fail_port_q;
      fail_data_d = fail_data_q;
      if (clr) begin
         logged_d    = 1'b0;
         fail_addr_d = '0;
         fail_port_d = 1'b0;
         fail_data_d = '0;
      end else if (!logged_q && miss_a) begin
         logged_d    = 1'b1;
         fail_addr_d = tail.addr_a;
         fail_port_d = 1'b0;
         fail_data_d = douta;
      end else if (!logged_q && miss_b) begin
         logged_d    = 1'b1;
         fail_addr_d = tail.addr_b;
         fail_port_d = 1'b1;
         fail_data_d = doutb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         logged_q    <= 1'b0;
         fail_addr_q <= '0;
         fail_port_q <= 1'b0;
         fail_data_q <= '0;
      end else begin
         logged_q    <= logged_d;
         fail_addr_q <= fail_addr_d;
         fail_port_q <= fail_port_d;
         fail_data_q <= fail_data_d;
      end
   end

   assign fail_addr = fail_addr_q;
   assign fail_port = fail_port_q;
   assign fail_data = fail_data_q;
`else
   logic unused_log;
   assign unused_log = ^{tail.addr_a, tail.addr_b};
   assign fail_addr  = '0;
   assign fail_port  = 1'b0;
   assign fail_data  = '0;
`endif

endmodule

// File: rtl/dpram_bist.sv
// dpram_bist: four-phase march BIST controller (W0, R0, W1, R1) for a dual-port RAM.
// BIST_ERR_LOG_EN enables first-fail capture on fail_addr/fail_port/fail_data.
module dpram_bist
   import dpram_bist_pkg::*;
#(
   parameter int                ADDR_W   = 2,
   parameter int                DATA_W   = 4,
   parameter logic [DATA_W-1:0] PATTERN  = 4'hA,
   parameter int                READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W+2:0] err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic              fail_port,
   output logic [DATA_W-1:0] fail_data,
   dpram_bist_if.master      ram
);

   localparam int unsigned       DEPTH      = phase_len(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
   localparam logic [1:0]        LAST_DRAIN = 2'(READ_LAT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [1:0]        drain_q, drain_d;

   logic              wea, web, rd_vld;
   logic [ADDR_W-1:0] addra, addrb;
   logic [DATA_W-1:0] dina, dinb, exp_a, exp_b;

   function automatic logic [DATA_W-1:0] d_of(input logic [ADDR_W-1:0] i);
      return DATA_W'(march_data(MAX_W'(PATTERN), MAX_W'(i)));
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      drain_d = drain_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = W0;
               idx_d   = '0;
            end
         end
         W0, R0, W1, R1: begin
            // The index wraps to 0 on the last address, ready for the next phase.
            idx_d = idx_q + ADDR_W'(1);
            if (idx_q == LAST_IDX) begin
               case (state_q)
                  W0:      state_d = R0;
                  R0:      state_d = W1;
                  W1:      state_d = R1;
                  default: state_d = DRAIN;
               endcase
            end
         end
         DRAIN: begin
            drain_d = drain_q + 2'd1;
            if (drain_q == LAST_DRAIN) begin
               state_d = DONE;
               drain_d = '0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read phases walk port B downwards; ~idx equals DEPTH-1-idx and never meets port A.
   always_comb begin
      wea    = 1'b0;
      web    = 1'b0;
      addra  = '0;
      addrb  = '0;
      dina   = '0;
      dinb   = '0;
      rd_vld = 1'b0;
      exp_a  = '0;
      exp_b  = '0;
      unique case (state_q)
         W0: begin
            wea   = 1'b1;
            addra = idx_q;
            dina  = d_of(idx_q);
         end
         W1: begin
            web   = 1'b1;
            addrb = idx_q;
            dinb  = ~d_of(idx_q);
         end
         R0: begin
            addra  = idx_q;
            addrb  = ~idx_q;
            rd_vld = 1'b1;
            exp_a  = d_of(idx_q);
            exp_b  = d_of(~idx_q);
         end
         R1: begin
            addra  = idx_q;
            addrb  = ~idx_q;
            rd_vld = 1'b1;
            exp_a  = ~d_of(idx_q);
            exp_b  = ~d_of(~idx_q);
         end
         default: ;
      endcase
   end

   assign ram.wea   = wea;
   assign ram.web   = web;
   assign ram.addra = addra;
   assign ram.addrb = addrb;
   assign ram.dina  = dina;
   assign ram.dinb  = dinb;

   assign busy = (state_q != IDLE) && (state_q != DONE);
   assign done = (state_q == DONE);

   dpram_bist_checker #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .READ_LAT (READ_LAT)
   ) u_checker (
      .clk       (clk),
      .rst       (rst),
      .clr       ((state_q == IDLE) && start),
      .fin       ((state_q == DRAIN) && (drain_q == LAST_DRAIN)),
      .rd_vld    (rd_vld),
      .addr_a    (addra),
      .addr_b    (addrb),
      .exp_a     (exp_a),
      .exp_b     (exp_b),
      .douta     (ram.douta),
      .doutb     (ram.doutb),
      .err_count (err_count),
      .pass      (pass),
      .fail_addr (fail_addr),
      .fail_port (fail_port),
      .fail_data (fail_data)
   );

endmodule
